// File: rtl/reaction_timer_ctrl_pkg.sv
// Shared types and constants for the reaction timer controller.
// Holds the round state encoding, the display digit format and the LFSR step.
package rt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    MEASURE,
    DONE,
    CHEAT
  } state_t;

  localparam logic [3:0]  DIGIT_BLANK = 4'hF;

  // Taps 16,14,13,11 of a left-shifting Fibonacci LFSR (bits 15,13,12,10).
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  // Element [0] is the ones digit, element [3] the thousands digit.
  typedef logic [3:0][3:0] bcd4_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_timer_ctrl_bcd_counter4.sv
// Four-digit BCD millisecond counter with decimal carry, saturation at 9999
// and a blank load that drives every digit to DIGIT_BLANK.
module bcd_counter4
  import rt_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_clr,
  input  logic  i_inc,
  input  logic  i_blank,
  output bcd4_t o_bcd,
  output logic  o_sat
);

  bcd4_t r_bcd;
  bcd4_t w_next;
  logic  w_carry;

  assign o_bcd = r_bcd;
  assign o_sat = (r_bcd == 16'h9999);

  // NOTE: blocking assignments let the carry ripple digit by digit within one evaluation.
  always_comb begin
    w_next  = r_bcd;
    w_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_bcd[i] == 4'd9) begin
          w_next[i] = 4'd0;
        end else begin
          w_next[i] = r_bcd[i] + 4'd1;
          w_carry   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd <= '0;
    end else if (i_blank) begin
      r_bcd <= {4{DIGIT_BLANK}};
    end else if (i_clr) begin
      r_bcd <= '0;
    end else if (i_inc && !o_sat) begin
      r_bcd <= w_next;
    end
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction timer round controller: random stimulus delay, BCD millisecond
// measurement, cheat and timeout detection, registered display digits.
module reaction_timer_ctrl
  import rt_pkg::*;
#(
  parameter int unsigned TICK_CYCLES  = 100000,
  parameter int unsigned MIN_DELAY_MS = 2000,
  parameter int unsigned RAND_BITS    = 11,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       clear_btn,
  output logic [3:0] k0,
  output logic [3:0] k1,
  output logic [3:0] k2,
  output logic [3:0] k3,
  output logic       led_stim,
  output logic       cheat,
  output logic       timeout,
  output logic       busy
);

  localparam int unsigned DIV_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned DELAY_W = $clog2(MIN_DELAY_MS + (2 ** RAND_BITS) + 1);

  state_t             r_state;
  logic               r_start_q, r_stop_q, r_clear_q;
  logic [15:0]        r_lfsr;
  logic [DIV_W-1:0]   r_div;
  logic [DELAY_W-1:0] r_delay;
  logic               r_led, r_cheat, r_timeout, r_busy;

  logic  w_start_rise, w_stop_rise, w_clear_rise, w_tick;
  logic  w_go_wait, w_go_meas;
  logic  w_cnt_clr, w_cnt_inc, w_cnt_blank, w_sat;
  bcd4_t w_bcd;

  assign w_start_rise = start_btn & ~r_start_q;
  assign w_stop_rise  = stop_btn  & ~r_stop_q;
  assign w_clear_rise = clear_btn & ~r_clear_q;
  assign w_tick       = (r_div == DIV_W'(TICK_CYCLES - 1));

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_go_wait   = 1'b0;
    w_go_meas   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cnt_blank = 1'b0;
    if (w_clear_rise) begin
      w_cnt_clr = 1'b1;
    end else begin
      case (r_state)
        IDLE, DONE, CHEAT: w_go_wait = w_start_rise;
        WAIT: begin
          w_cnt_blank = w_stop_rise;
          w_go_meas   = !w_stop_rise && w_tick && (r_delay < DELAY_W'(2));
        end
        MEASURE: w_cnt_inc = !w_stop_rise && w_tick && !w_sat;
        default: ;
      endcase
      w_cnt_clr = w_go_wait;
    end
  end

  // The tick phase restarts on each entry to WAIT or MEASURE so the first
  // millisecond of either phase is a full one.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_start_q <= 1'b0;
      r_stop_q  <= 1'b0;
      r_clear_q <= 1'b0;
      r_lfsr    <= LFSR_SEED;
      r_div     <= '0;
    end else begin
      r_start_q <= start_btn;
      r_stop_q  <= stop_btn;
      r_clear_q <= clear_btn;
      r_lfsr    <= lfsr_next(r_lfsr);
      if (w_go_wait || w_go_meas || w_tick) r_div <= '0;
      else                                  r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_delay   <= '0;
      r_led     <= 1'b0;
      r_cheat   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else if (w_clear_rise) begin
      r_state   <= IDLE;
      r_led     <= 1'b0;
      r_cheat   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else if (w_go_wait) begin
      r_state   <= WAIT;
      r_delay   <= DELAY_W'(MIN_DELAY_MS) + DELAY_W'(r_lfsr[RAND_BITS-1:0]);
      r_led     <= 1'b0;
      r_cheat   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        WAIT: begin
          if (w_stop_rise) begin
            r_state <= CHEAT;
            r_cheat <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_go_meas) begin
            r_state <= MEASURE;
            r_led   <= 1'b1;
          end else if (w_tick) begin
            r_delay <= r_delay - DELAY_W'(1);
          end
        end
        MEASURE: begin
          if (w_stop_rise || (w_tick && w_sat)) begin
            r_state   <= DONE;
            r_led     <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= !w_stop_rise;
          end
        end
        default: ;
      endcase
    end
  end

  bcd_counter4 u_bcd_counter4 (
    .clk     (clk_100MHz),
    .rst_n   (reset_n),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .i_blank (w_cnt_blank),
    .o_bcd   (w_bcd),
    .o_sat   (w_sat)
  );

  assign k0       = w_bcd[0];
  assign k1       = w_bcd[1];
  assign k2       = w_bcd[2];
  assign k3       = w_bcd[3];
  assign led_stim = r_led;
  assign cheat    = r_cheat;
  assign timeout  = r_timeout;
  assign busy     = r_busy;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl: normal round, cheat, coincident
// events, clear priority, asynchronous reset and timeout saturation.
module tb_reaction_timer_ctrl;

  // A short tick keeps the full 9999-count timeout round affordable.
  localparam int unsigned T = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_btn, stop_btn, clear_btn;
  logic [3:0] k0, k1, k2, k3;
  logic       led_stim, cheat, timeout, busy;

  logic [15:0] digits;
  logic [3:0]  flags;
  logic [15:0] m_lfsr;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          d;

  assign digits = {k3, k2, k1, k0};
  assign flags  = {led_stim, cheat, timeout, busy};

  always #5 clk = ~clk;

  reaction_timer_ctrl #(
    .TICK_CYCLES  (T),
    .MIN_DELAY_MS (2),
    .RAND_BITS    (2),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk_100MHz (clk),
    .reset_n    (reset_n),
    .start_btn  (start_btn),
    .stop_btn   (stop_btn),
    .clear_btn  (clear_btn),
    .k0         (k0),
    .k1         (k1),
    .k2         (k2),
    .k3         (k3),
    .led_stim   (led_stim),
    .cheat      (cheat),
    .timeout    (timeout),
    .busy       (busy)
  );

  // Reference LFSR: taps 16,14,13,11, advancing on every clock out of reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stimulus delay in ms is MIN_DELAY_MS plus the LFSR low bits at the start edge.
  task automatic press_start(output int delay_ms);
    delay_ms  = 2 + int'(m_lfsr[1:0]);
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    start_btn = 1'b0;
    stop_btn  = 1'b0;
    clear_btn = 1'b0;
    #12;
    check("reset digits", digits, 16'h0000);
    check("reset flags", {12'h0, flags}, 16'h0000);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(3);

    // Normal round, stop after 123 measured ticks.
    press_start(d);
    check("s1 wait flags", {12'h0, flags}, 16'h0001);
    step(d * T - 1);
    check("s1 pre-stim flags", {12'h0, flags}, 16'h0001);
    step(1);
    check("s1 stim flags", {12'h0, flags}, 16'h0009);
    check("s1 stim digits", digits, 16'h0000);
    step(123 * T);
    check("s1 count 123", digits, 16'h0123);
    stop_btn = 1'b1; step(1); stop_btn = 1'b0;
    check("s1 done digits", digits, 16'h0123);
    check("s1 done flags", {12'h0, flags}, 16'h0000);

    // Stop coincides with the tick that would take 0041 to 0042.
    press_start(d);
    check("s4a restart digits", digits, 16'h0000);
    step(d * T + 41 * T);
    check("s4a count 41", digits, 16'h0041);
    step(T - 1);
    stop_btn = 1'b1; step(1); stop_btn = 1'b0;
    check("s4a frozen digits", digits, 16'h0041);
    check("s4a done flags", {12'h0, flags}, 16'h0000);

    // Early stop one tick into WAIT.
    press_start(d);
    step(T);
    stop_btn = 1'b1; step(1); stop_btn = 1'b0;
    check("s2 cheat flags", {12'h0, flags}, 16'h0004);
    check("s2 cheat digits", digits, 16'hFFFF);
    step(6 * T);
    check("s2 led stays off", {12'h0, flags}, 16'h0004);
    press_start(d);
    check("s2 restart flags", {12'h0, flags}, 16'h0001);
    check("s2 restart digits", digits, 16'h0000);

    // Stop on the delay-expiry tick: cheat wins.
    step(d * T - 1);
    stop_btn = 1'b1; step(1); stop_btn = 1'b0;
    check("s4b cheat flags", {12'h0, flags}, 16'h0004);
    check("s4b cheat digits", digits, 16'hFFFF);

    // Clear and stop together mid-MEASURE.
    press_start(d);
    step(d * T + 5 * T);
    check("s5 count 5", digits, 16'h0005);
    clear_btn = 1'b1; stop_btn = 1'b1; step(1);
    clear_btn = 1'b0; stop_btn = 1'b0;
    check("s5 idle digits", digits, 16'h0000);
    check("s5 idle flags", {12'h0, flags}, 16'h0000);

    // Asynchronous reset mid-MEASURE, then mid-WAIT, with no clock edge.
    press_start(d);
    step(d * T + 3 * T);
    check("s6 count 3", digits, 16'h0003);
    #2 reset_n = 1'b0;
    #1;
    check("s6 meas reset digits", digits, 16'h0000);
    check("s6 meas reset flags", {12'h0, flags}, 16'h0000);
    step(1);
    reset_n = 1'b1;
    step(2);
    press_start(d);
    check("s6 wait flags", {12'h0, flags}, 16'h0001);
    step(2);
    #2 reset_n = 1'b0;
    #1;
    check("s6 wait reset flags", {12'h0, flags}, 16'h0000);
    step(1);
    reset_n = 1'b1;
    step(5);

    // LFSR restarted from ACE1: stimulus timing must follow the model again.
    press_start(d);
    step(d * T - 1);
    check("s6 lfsr pre-stim", {12'h0, flags}, 16'h0001);
    step(1);
    check("s6 lfsr stim", {12'h0, flags}, 16'h0009);

    // Timeout: no stop, count saturates at 9999.
    step(9999 * T);
    check("s3 count 9999", digits, 16'h9999);
    step(T);
    check("s3 timeout digits", digits, 16'h9999);
    check("s3 timeout flags", {12'h0, flags}, 16'h0002);
    step(3 * T);
    check("s3 hold digits", digits, 16'h9999);
    check("s3 hold flags", {12'h0, flags}, 16'h0002);
    clear_btn = 1'b1; step(1); clear_btn = 1'b0;
    check("s3 clear digits", digits, 16'h0000);
    check("s3 clear flags", {12'h0, flags}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
